// File: rtl/next_pc_pkg.sv
// rtl/next_pc_pkg.sv - shared cause codes, FSM state and default vector for next_pc_ctrl
package next_pc_pkg;

    localparam logic [1:0] CAUSE_NONE     = 2'd0;
    localparam logic [1:0] CAUSE_ILLEGAL  = 2'd1;
    localparam logic [1:0] CAUSE_TIMEOUT  = 2'd2;
    localparam logic [1:0] CAUSE_MISALIGN = 2'd3;

    localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'h0000_0080;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

endpackage

// File: rtl/pc_target_calc.sv
// rtl/pc_target_calc.sv - combinational pc+4, branch and jump target generation
module pc_target_calc #(
    parameter int N = 32
) (
    input  logic [N-1:0] pc,
    input  logic [15:0]  imm16,
    input  logic [25:0]  jidx26,
    output logic [N-1:0] pc4,
    output logic [N-1:0] branch_target,
    output logic [N-1:0] jump_target
);

    logic [N-1:0] branch_offset;

    assign pc4           = pc + N'(4);
    assign branch_offset = {{(N-18){imm16[15]}}, imm16, 2'b00};
    assign branch_target = pc4 + branch_offset;
    // Jump stays within the 256 MB region of the delay-slot address.
    assign jump_target   = {pc4[N-1:N-4], jidx26, 2'b00};

endmodule

// File: rtl/next_pc_ctrl.sv
// rtl/next_pc_ctrl.sv - next-PC select with trap/ERET, stall watchdog and double-fault halt
// Optional misaligned-target trap: NEXT_PC_MISALIGN_TRAP_EN
module next_pc_ctrl
    import next_pc_pkg::*;
#(
    parameter int           N             = 32,
    parameter logic [N-1:0] EXC_VECTOR    = N'(EXC_VECTOR_DEFAULT),
    parameter int           STALL_TIMEOUT = 16
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [N-1:0] pc,
    input  logic [15:0]  imm16,
    input  logic [25:0]  jidx26,
    input  logic [N-1:0] rs_data,
    input  logic         branch,
    input  logic         zero,
    input  logic         jump,
    input  logic         jr,
    input  logic         stall,
    input  logic         exc_req,
    input  logic         eret,
    output logic [N-1:0] pc_bar,
    output logic [N-1:0] epc,
    output logic [1:0]   cause,
    output logic         in_handler,
    output logic         halted
);

    localparam int            CW        = $clog2(STALL_TIMEOUT) + 1;
    localparam logic [CW-1:0] CNT_LIMIT = CW'(STALL_TIMEOUT - 1);

    state_t        state, state_next;
    logic [CW-1:0] stall_cnt, cnt_next;
    logic [N-1:0]  epc_next;
    logic [1:0]    cause_next;
    logic          in_handler_next;

    logic [N-1:0]  pc4, branch_target, jump_target, target;
    logic          timeout, misalign, trap;
    logic [1:0]    trap_cause;

    pc_target_calc #(.N(N)) u_target (
        .pc            (pc),
        .imm16         (imm16),
        .jidx26        (jidx26),
        .pc4           (pc4),
        .branch_target (branch_target),
        .jump_target   (jump_target)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_RUN;
            stall_cnt  <= '0;
            epc        <= '0;
            cause      <= CAUSE_NONE;
            in_handler <= 1'b0;
        end else begin
            state      <= state_next;
            stall_cnt  <= cnt_next;
            epc        <= epc_next;
            cause      <= cause_next;
            in_handler <= in_handler_next;
        end
    end

    always_comb begin
        state_next      = state;
        cnt_next        = stall_cnt;
        epc_next        = epc;
        cause_next      = cause;
        in_handler_next = in_handler;
        pc_bar          = pc;
        target          = pc4;
        timeout         = 1'b0;
        misalign        = 1'b0;
        trap            = 1'b0;
        trap_cause      = CAUSE_NONE;

        case (state)
            ST_RUN: begin
                timeout = stall && (stall_cnt == CNT_LIMIT);

                if (eret)                 target = epc;
                else if (stall)           target = pc;
                else if (jr)              target = rs_data;
                else if (jump)            target = jump_target;
                else if (branch && zero)  target = branch_target;
                else                      target = pc4;

`ifdef NEXT_PC_MISALIGN_TRAP_EN
                // Only computed targets are checked; hold and pc+4 cannot misalign.
                misalign = (eret || (!stall && (jr || jump || (branch && zero))))
                           && (target[1:0] != 2'b00);
`else
                misalign = 1'b0;
`endif

                trap = exc_req || timeout || misalign;
                if (exc_req)      trap_cause = CAUSE_ILLEGAL;
                else if (timeout) trap_cause = CAUSE_TIMEOUT;
                else              trap_cause = CAUSE_MISALIGN;

                if (trap) begin
                    pc_bar   = EXC_VECTOR;
                    cnt_next = '0;
                    if (!in_handler) begin
                        epc_next        = pc;
                        cause_next      = trap_cause;
                        in_handler_next = 1'b1;
                    end else begin
                        state_next = ST_HALT;
                    end
                end else begin
                    pc_bar = target;
                    if (eret && in_handler) in_handler_next = 1'b0;
                    if (!stall)                  cnt_next = '0;
                    else if (stall_cnt != CNT_LIMIT) cnt_next = stall_cnt + 1'b1;
                end
            end
            ST_HALT: begin
                pc_bar = pc;
            end
            default: begin
                state_next = ST_RUN;
            end
        endcase
    end

    assign halted = (state == ST_HALT);

endmodule

// File: tb/tb_next_pc_ctrl.sv
// tb/tb_next_pc_ctrl.sv - scoreboard bench for next_pc_ctrl
module tb_next_pc_ctrl;

    logic        clk;
    logic        reset_n;
    logic [31:0] pc;
    logic [15:0] imm16;
    logic [25:0] jidx26;
    logic [31:0] rs_data;
    logic        branch, zero, jump, jr, stall, exc_req, eret;
    logic [31:0] pc_bar;
    logic [31:0] epc;
    logic [1:0]  cause;
    logic        in_handler;
    logic        halted;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t exp_q[$];
    exp_t exp_cur;
    int   n_tests = 0;
    int   n_fail  = 0;

    next_pc_ctrl dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .pc         (pc),
        .imm16      (imm16),
        .jidx26     (jidx26),
        .rs_data    (rs_data),
        .branch     (branch),
        .zero       (zero),
        .jump       (jump),
        .jr         (jr),
        .stall      (stall),
        .exc_req    (exc_req),
        .eret       (eret),
        .pc_bar     (pc_bar),
        .epc        (epc),
        .cause      (cause),
        .in_handler (in_handler),
        .halted     (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // pc_bar is sampled mid-cycle, away from the active edge
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_cur = exp_q.pop_front();
            check(exp_cur.tag, pc_bar, exp_cur.val);
        end
    end

    task automatic cyc(input string tag, input logic [31:0] exp);
        exp_t e;
        e.tag = tag;
        e.val = exp;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic clear_ctrl();
        branch = 0; zero = 0; jump = 0; jr = 0; stall = 0; exc_req = 0; eret = 0;
        imm16 = '0; jidx26 = '0; rs_data = '0;
    endtask

    task automatic check_regs(input string tag, input logic [31:0] e_epc, input logic [1:0] e_cause,
                              input logic e_inh, input logic e_halt);
        check({tag, "_epc"},   epc,        e_epc);
        check({tag, "_cause"}, 32'(cause), 32'(e_cause));
        check({tag, "_inh"},   32'(in_handler), 32'(e_inh));
        check({tag, "_halt"},  32'(halted),     32'(e_halt));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] exp_bt;
        reset_n = 0;
        pc = '0;
        clear_ctrl();
        #12;
        check_regs("reset", 32'h0, 2'd0, 1'b0, 1'b0);
        check("reset_pcbar", pc_bar, 32'h4);
        reset_n = 1;
        @(posedge clk); #1;

        // Sequential and branch
        pc = 32'h100;
        cyc("seq", 32'h104);
        branch = 1; zero = 1; imm16 = 16'hFFFE;
        cyc("br_taken", 32'h0FC);
        zero = 0;
        cyc("br_not_taken", 32'h104);
        zero = 1;
        for (int i = 0; i < 8; i++) begin
            pc    = $urandom & 32'hFFFF_FFFC;
            imm16 = 16'($urandom);
            exp_bt = pc + 32'd4 + {{14{imm16[15]}}, imm16, 2'b00};
            cyc("br_rand", exp_bt);
        end
        clear_ctrl();

        // Jump and jr priority
        pc = 32'h1000_0000; jump = 1; jidx26 = 26'h40;
        cyc("jump", 32'h1000_0100);
        jr = 1; rs_data = 32'h2000;
        cyc("jr_over_jump", 32'h2000);
        clear_ctrl();
        check_regs("after_jump", 32'h0, 2'd0, 1'b0, 1'b0);

`ifdef NEXT_PC_MISALIGN_TRAP_EN
        pc = 32'h40; jr = 1; rs_data = 32'h2002;
        cyc("misalign_trap", 32'h80);
        check_regs("misalign", 32'h40, 2'd3, 1'b1, 1'b0);
        clear_ctrl(); pc = 32'h80; eret = 1;
        cyc("misalign_eret", 32'h40);
        clear_ctrl();
`else
        pc = 32'h40; jr = 1; rs_data = 32'h2002;
        cyc("misalign_pass", 32'h2002);
        check_regs("misalign_off", 32'h0, 2'd0, 1'b0, 1'b0);
        clear_ctrl();
`endif

        // Exception and return; eret also loses to a simultaneous trap
        pc = 32'h200; exc_req = 1; eret = 1;
        cyc("exc", 32'h80);
        check_regs("exc", 32'h200, 2'd1, 1'b1, 1'b0);
        clear_ctrl(); pc = 32'h80;
        cyc("handler_seq", 32'h84);
        pc = 32'h84; eret = 1;
        cyc("eret", 32'h200);
        check_regs("eret", 32'h200, 2'd1, 1'b0, 1'b0);
        pc = 32'h40;
        cyc("eret_idle", 32'h200);
        check_regs("eret_idle", 32'h200, 2'd1, 1'b0, 1'b0);
        clear_ctrl();

        // Stall timeout at the 16th consecutive stall cycle
        pc = 32'h300; stall = 1;
        repeat (15) cyc("stall_hold", 32'h300);
        cyc("stall_timeout", 32'h80);
        check_regs("timeout", 32'h300, 2'd2, 1'b1, 1'b0);
        stall = 0; pc = 32'h80; eret = 1;
        cyc("timeout_eret", 32'h300);
        clear_ctrl();

        // Dropping stall clears the counter
        pc = 32'h300; stall = 1;
        repeat (10) cyc("stall_short", 32'h300);
        stall = 0;
        cyc("stall_release", 32'h304);
        stall = 1;
        repeat (15) cyc("stall_again", 32'h300);
        stall = 0;
        cyc("stall_release2", 32'h304);
        check_regs("no_timeout", 32'h300, 2'd2, 1'b0, 1'b0);

        // Double fault
        pc = 32'h500; exc_req = 1;
        cyc("df_first", 32'h80);
        check_regs("df_first", 32'h500, 2'd1, 1'b1, 1'b0);
        pc = 32'h80;
        cyc("df_second", 32'h80);
        check_regs("df_halt", 32'h500, 2'd1, 1'b1, 1'b1);
        clear_ctrl(); jump = 1; exc_req = 1; pc = 32'h1234;
        cyc("halt_track", 32'h1234);
        pc = 32'h88;
        cyc("halt_track2", 32'h88);
        clear_ctrl();

        // Async reset while halted
        #2; reset_n = 0; #1;
        check_regs("rst_halt", 32'h0, 2'd0, 1'b0, 1'b0);
        pc = 32'h0;
        #1; reset_n = 1;
        @(posedge clk); #1;
        cyc("post_rst", 32'h4);

        // Async reset mid-stall with counter at 7
        pc = 32'h600; exc_req = 1;
        cyc("pre_stall_exc", 32'h80);
        clear_ctrl(); pc = 32'h80; stall = 1;
        repeat (7) cyc("stall7", 32'h80);
        #2; reset_n = 0; #1;
        check_regs("rst_stall", 32'h0, 2'd0, 1'b0, 1'b0);
        stall = 0; pc = 32'h0;
        #1; reset_n = 1;
        @(posedge clk); #1;
        cyc("post_rst2", 32'h4);
        pc = 32'h300; stall = 1;
        repeat (15) cyc("stall_after_rst", 32'h300);
        stall = 0;
        cyc("stall_after_rst_rel", 32'h304);
        check_regs("final", 32'h0, 2'd0, 1'b0, 1'b0);

        @(posedge clk); #1;
        check("sb_drain", 32'(exp_q.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
